// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply/divide unit with HI/LO registers.
// One radix-2 step per clock: shift-add multiply, restoring divide, sign fix-up at the end.
module mult_div_unit (
  input  logic        i_clk,
  input  logic        i_arst,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_oprd1,
  input  logic [31:0] i_oprd2,
  input  logic        i_hi_we,
  input  logic        i_lo_we,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [4:0]  r_cnt;
  logic        r_busy, r_done;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_a_raw;   // dividend as presented, returned in HI on divide by zero
  logic [31:0] r_b;       // multiplicand / divisor magnitude
  logic [31:0] r_q;       // multiplier -> product low / dividend -> quotient
  logic [31:0] r_rem;     // product high / partial remainder
  logic        r_neg_a, r_neg_b, r_divz;

  logic        w_sa, w_sb;
  logic [31:0] w_mag_a, w_mag_b;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_sh;
  logic        w_div_ge;
  logic [31:0] w_div_diff;
  logic [63:0] w_prod, w_prod_s;
  logic [31:0] w_quo, w_rem;

  // Signed ops (op[0]==0) work on magnitudes; signs are reapplied in FIX.
  assign w_sa    = ~i_op[0] & i_oprd1[31];
  assign w_sb    = ~i_op[0] & i_oprd2[31];
  assign w_mag_a = w_sa ? -i_oprd1 : i_oprd1;
  assign w_mag_b = w_sb ? -i_oprd2 : i_oprd2;

  assign w_mul_sum  = {1'b0, r_rem} + {1'b0, (r_q[0] ? r_b : 32'd0)};
  assign w_div_sh   = {r_rem, r_q[31]};
  assign w_div_ge   = w_div_sh >= {1'b0, r_b};
  // When the subtraction succeeds the true difference is below the divisor, so 32 bits suffice.
  assign w_div_diff = w_div_sh[31:0] - r_b;

  assign w_prod   = {r_rem, r_q};
  assign w_prod_s = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
  assign w_quo    = (r_neg_a ^ r_neg_b) ? -r_q : r_q;
  assign w_rem    = r_neg_a ? -r_rem : r_rem;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state <= S_IDLE;
      r_op    <= 2'b00;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_a_raw <= 32'd0;
      r_b     <= 32'd0;
      r_q     <= 32'd0;
      r_rem   <= 32'd0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_divz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Moves to HI/LO only land while idle; the FIX edge still has busy set.
      if (!r_busy) begin
        if (i_hi_we) r_hi <= i_wdata;
        if (i_lo_we) r_lo <= i_wdata;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op    <= i_op;
            r_a_raw <= i_oprd1;
            r_q     <= w_mag_a;
            r_b     <= w_mag_b;
            r_rem   <= 32'd0;
            r_neg_a <= w_sa;
            r_neg_b <= w_sb;
            r_divz  <= i_op[1] & (i_oprd2 == 32'd0);
            r_cnt   <= 5'd0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_op[1]) begin
            r_rem <= w_div_ge ? w_div_diff : w_div_sh[31:0];
            r_q   <= {r_q[30:0], w_div_ge};
          end else begin
            r_rem <= w_mul_sum[32:1];
            r_q   <= {w_mul_sum[0], r_q[31:1]};
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_op[1]) begin
            r_hi <= w_prod_s[63:32];
            r_lo <= w_prod_s[31:0];
          end else if (r_divz) begin
            r_hi <= r_a_raw;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus hand sequences for
// ignored starts/moves, moves at start and FIX edges, and mid-operation reset.
module tb_mult_div_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic        clk = 1'b0;
  logic        arst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] oprd1, oprd2, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  mult_div_unit dut (
    .i_clk(clk), .i_arst(arst), .i_start(start), .i_op(op),
    .i_oprd1(oprd1), .i_oprd2(oprd2), .i_hi_we(hi_we), .i_lo_we(lo_we),
    .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, ehi, elo;
    string       name;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // mode 0 plain, 1 disturbances while busy, 2 MTHI/MTLO with start, 3 MTHI/MTLO at FIX edge
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input string nm, input int mode);
    int busy_cnt = 0, done_cnt = 0, done_k = -1, hold_bad = 0;
    logic [31:0] hi33 = 32'd0, lo33 = 32'd0;
    @(negedge clk);
    op = o; oprd1 = a; oprd2 = b; start = 1'b1;
    if (mode == 2) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_0001; end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    if (mode == 2) begin m_hi = 32'h5A5A_0001; m_lo = 32'h5A5A_0001; end
    for (int k = 0; k < 80; k++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (done_k < 0) done_k = k; end
      if (k < 33 && (hi !== m_hi || lo !== m_lo)) hold_bad++;
      if (k == 33) begin hi33 = hi; lo33 = lo; end
      if (mode == 1 && k == 5) begin
        start = 1'b1; op = DIVU; oprd1 = 32'd99; oprd2 = 32'd1;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (mode == 1 && k == 6) begin start = 1'b0; hi_we = 1'b0; oprd1 = 32'h1234; end
      if (mode == 3 && k == 32) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_0000; end
      if (mode == 3 && k == 33) begin hi_we = 1'b0; lo_we = 1'b0; end
      @(negedge clk);
    end
    chk({nm, " hi"}, {32'd0, hi33}, {32'd0, ehi});
    chk({nm, " lo"}, {32'd0, lo33}, {32'd0, elo});
    chk({nm, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({nm, " done_cycle"}, 64'(done_k), 64'd33);
    chk({nm, " done_count"}, 64'(done_cnt), 64'd1);
    chk({nm, " hold_while_busy"}, 64'(hold_bad), 64'd0);
    m_hi = ehi; m_lo = elo;
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    vecs[1]  = '{MULT,  -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7"};
    vecs[2]  = '{MULTU, 32'd3, 32'd7, 32'd0, 32'd21, "multu_3x7"};
    vecs[3]  = '{DIV,   -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2"};
    vecs[4]  = '{DIVU,  32'd7, 32'd2, 32'd1, 32'd3, "divu_7d2"};
    vecs[5]  = '{DIVU,  32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, "divu_by0"};
    vecs[6]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf"};
    vecs[7]  = '{DIV,   32'd7, -32'sd2, 32'd1, 32'hFFFF_FFFD, "div_7dm2"};
    vecs[8]  = '{MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, "mult_m1xm1"};
    vecs[9]  = '{DIV,   -32'sd5, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_m5_by0"};
    vecs[10] = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, "mult_minxmin"};

    arst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = MULT; oprd1 = 32'd0; oprd2 = 32'd0; wdata = 32'd0;
    #3;
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    @(negedge clk);
    arst = 1'b0;

    // MTHI and MTLO together while idle
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_2222;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_idle hi", {32'd0, hi}, {32'd0, 32'h1111_2222});
    chk("mt_idle lo", {32'd0, lo}, {32'd0, 32'h1111_2222});
    m_hi = 32'h1111_2222; m_lo = 32'h1111_2222;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].name, 0);

    run_op(MULTU, 32'd5, 32'd6, 32'd0, 32'd30, "disturb", 1);
    run_op(MULTU, 32'd3, 32'd7, 32'd0, 32'd21, "mt_start", 2);
    run_op(DIVU,  32'd7, 32'd2, 32'd1, 32'd3, "mt_fix", 3);

    // Reset after E10 of a DIVU
    @(negedge clk);
    op = DIVU; oprd1 = 32'd1000; oprd2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 arst = 1'b1;
    #1;
    chk("abort hi", {32'd0, hi}, 64'd0);
    chk("abort lo", {32'd0, lo}, 64'd0);
    chk("abort busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    arst = 1'b0;
    begin
      int dcnt = 0, bcnt = 0;
      for (int k = 0; k < 40; k++) begin
        if (done) dcnt++;
        if (busy) bcnt++;
        @(negedge clk);
      end
      chk("abort no_done", 64'(dcnt), 64'd0);
      chk("abort no_busy", 64'(bcnt), 64'd0);
    end
    lo_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    lo_we = 1'b0;
    chk("post_reset mtlo lo", {32'd0, lo}, {32'd0, 32'h0000_1234});
    chk("post_reset mtlo hi", {32'd0, hi}, 64'd0);
    m_hi = 32'd0; m_lo = 32'h0000_1234;
    run_op(DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, "post_reset_divu", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 i_arst  in  1  reset, asynchronous, active-high.
REQ-004 i_start  in  1  request a new operation; sampled only when o_busy=0.
REQ-005 i_op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 i_oprd1  in  32  rs value (multiplicand or dividend).
REQ-007 i_oprd2  in  32  rt value (multiplier or divisor).
REQ-008 i_hi_we  in  1  MTHI write enable.
REQ-009 i_lo_we  in  1  MTLO write enable.
REQ-010 i_wdata  in  32  MTHI/MTLO write data.
REQ-011 o_busy  out  1  operation in progress.
REQ-012 o_done  out  1  one-cycle pulse when HI/LO receive a result.
REQ-013 o_hi  out  32  HI register, driven directly from the flop.
REQ-014 o_lo  out  32  LO register, driven directly from the flop.

Function
REQ-015 FSM states: IDLE, CALC, FIX; DONE is not a state, it is the o_done flop.
REQ-016 IDLE with i_start=1 at edge E0: latch i_op and the operands; for signed ops, latch operand magnitudes and sign bits; clear the 5-bit iteration counter; go to CALC.
REQ-017 CALC: one radix-2 iteration per edge, E1..E32 (shift-add multiply, restoring divide); counter value 31 at E32 moves the FSM to FIX.
REQ-018 FIX at edge E33: apply sign correction, write HI and LO, set o_done=1, go to IDLE.
REQ-019 o_busy = 1 from after E0 through after E32, and 0 otherwise; the earliest next start is sampled at E34.
REQ-020 o_done = 1 only for the cycle following E33.
REQ-021 MULT/MULTU: {HI,LO} = 64-bit product; for MULT, negate the product when the operand signs differ.
REQ-022 DIV/DIVU: LO = quotient, HI = remainder; for DIV, truncate toward zero (quotient sign = XOR of operand signs, remainder sign = dividend sign).
REQ-023 Divide by zero (divisor = 0, DIV or DIVU): LO = 32'hFFFF_FFFF, HI = i_oprd1 as latched; no exception; latency unchanged.
REQ-024 DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.
REQ-025 i_start while o_busy = 1: ignored; no queueing.
REQ-026 Operand and i_op changes after E0: no effect on the operation in progress.
REQ-027 HI and LO hold their values during CALC; they change only at FIX, on an MTHI/MTLO write, or on reset.
REQ-028 i_hi_we / i_lo_we with o_busy = 0: write i_wdata to HI / LO at that edge (both may be written together).
REQ-029 i_hi_we / i_lo_we with o_busy = 1: ignored.
REQ-030 MTHI/MTLO at the same edge as an accepted start: the write takes effect; the result at E33 overwrites it.
REQ-031 MTHI/MTLO at the FIX edge: ignored, because o_busy = 1 in that cycle; the result wins.

Reset
REQ-032 i_arst = 1 immediately sets FSM = IDLE, counter = 0, HI = 0, LO = 0, o_busy = 0, o_done = 0, independent of i_clk.
REQ-033 Reset asserted mid-operation aborts the operation; no o_done is produced; the first start after deassertion behaves normally.

Verification
REQ-034 MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> HI = 32'hFFFF_FFFE, LO = 32'h0000_0001; o_done high only in the cycle after E33; o_busy high for exactly 33 cycles.
REQ-035 MULT -3 x 7 -> HI = 32'hFFFF_FFFF, LO = 32'hFFFF_FFEB; MULTU 3 x 7 -> HI = 0, LO = 21.
REQ-036 DIV -7 / 2 -> LO = 32'hFFFF_FFFD, HI = 32'hFFFF_FFFF; DIVU 7 / 2 -> LO = 3, HI = 1.
REQ-037 DIVU 100 / 0 -> LO = 32'hFFFF_FFFF, HI = 32'h0000_0064; DIV 32'h8000_0000 / -1 -> LO = 32'h8000_0000, HI = 0.
REQ-038 During a MULTU 5 x 6: pulse i_start with other operands, pulse i_hi_we with data 32'hDEAD_BEEF, and change i_oprd1 -> result still HI = 0, LO = 30; no second o_done.
REQ-039 Assert i_arst after E10 of a DIVU -> HI = LO = 0 and o_busy = 0 at once; no o_done; a following MTLO of 32'h1234 -> LO = 32'h0000_1234.
